// File: rtl/lcd_byte_sender.sv
// Sends one LCD byte as two 4-bit nibbles through the write_cycle handshake, then waits the settle delay.
// Define LCD_LONG_DELAY_EN to give clear/home commands (rs=0, 8'h01/8'h02) the long settle delay.
module lcd_byte_sender #(
  parameter int DELAY_CYCLES      = 2000,
  parameter int LONG_DELAY_CYCLES = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs_in,
  input  logic [7:0] data_in,
  input  logic       wr_finish,
  output logic       wr_enable,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] lcd_db,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(LONG_DELAY_CYCLES + 1);
  localparam logic [CW-1:0] SHORT_LOAD = CW'(DELAY_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LOAD  = CW'(LONG_DELAY_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, HI_REQ, HI_WAIT, LO_REQ, LO_WAIT, DELAY} state_t;

  state_t          state;
  logic [7:0]      byte_q;
  logic            rs_q;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   dly_load;
  logic            clr_home;

  assign clr_home = !rs_q && (byte_q == 8'h01 || byte_q == 8'h02);

`ifdef LCD_LONG_DELAY_EN
  assign dly_load = clr_home ? LONG_LOAD : SHORT_LOAD;
`else
  // Long delay only sizes the counter in this build.
  logic unused_long;
  assign unused_long = &{1'b0, clr_home, LONG_LOAD};
  assign dly_load    = SHORT_LOAD;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      byte_q    <= 8'h00;
      rs_q      <= 1'b0;
      cnt       <= '0;
      wr_enable <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_rw    <= 1'b0;
      lcd_db    <= 4'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      wr_enable <= 1'b0;
      done      <= 1'b0;
      lcd_rw    <= 1'b0;
      case (state)
        IDLE: if (start) begin
          byte_q <= data_in;
          rs_q   <= rs_in;
          lcd_db <= data_in[7:4];
          lcd_rs <= rs_in;
          busy   <= 1'b1;
          state  <= HI_REQ;
        end
        HI_REQ: begin
          wr_enable <= 1'b1;
          state     <= HI_WAIT;
        end
        // A finish coincident with our own request pulse belongs to an older write.
        HI_WAIT: if (wr_finish && !wr_enable) begin
          lcd_db <= byte_q[3:0];
          state  <= LO_REQ;
        end
        LO_REQ: begin
          wr_enable <= 1'b1;
          state     <= LO_WAIT;
        end
        LO_WAIT: if (wr_finish && !wr_enable) begin
          cnt   <= dly_load;
          state <= DELAY;
        end
        DELAY: begin
          if (cnt == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_byte_sender.sv
// Directed bench for lcd_byte_sender with a write_cycle model that finishes 3 cycles after each request.
module tb_lcd_byte_sender;

  localparam int D  = 4;
`ifdef LCD_LONG_DELAY_EN
  localparam int LD = 10;
`else
  localparam int LD = 4;
`endif

  logic       clk = 1'b0;
  logic       rst, start, rs_in, wr_finish;
  logic [7:0] data_in;
  logic       wr_enable, lcd_rs, lcd_rw, busy, done;
  logic [3:0] lcd_db;
  logic [2:0] we_sh = 3'b000;

  always #5 clk = ~clk;

  lcd_byte_sender #(.DELAY_CYCLES(D), .LONG_DELAY_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .start(start), .rs_in(rs_in), .data_in(data_in),
    .wr_finish(wr_finish), .wr_enable(wr_enable), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_db(lcd_db), .busy(busy), .done(done)
  );

  always @(posedge clk) we_sh <= {we_sh[1:0], wr_enable};
  assign wr_finish = we_sh[2];

  // Monitor: logs the values present during the cycle that ends at this edge.
  int cyc = 0, we_cnt = 0, done_cnt = 0, fin_cyc = -1, done_cyc = -1;
  int nib_q[$], rsl_q[$], we_cyc[$];
  always @(posedge clk) begin
    if (wr_enable) begin
      we_cnt++;
      nib_q.push_back(int'(lcd_db));
      rsl_q.push_back(int'(lcd_rs));
      we_cyc.push_back(cyc);
    end
    if (wr_finish) fin_cyc = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    cyc++;
  end

  int errors = 0, checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    we_cnt = 0; done_cnt = 0; fin_cyc = -1; done_cyc = -1;
    nib_q.delete(); rsl_q.delete(); we_cyc.delete();
  endtask

  task automatic wait_done(input int n, input string name);
    int k;
    k = 0;
    while (done_cnt < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt < n) chk({name, ".timeout"}, done_cnt, n);
  endtask

  function automatic int qget(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  task automatic run_byte(input logic r, input logic [7:0] d, input logic [3:0] hi,
                          input logic [3:0] lo, input int dly, input string tag);
    clear_logs();
    @(negedge clk);
    start = 1'b1; rs_in = r; data_in = d;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".busy_hi"}, int'(busy), 1);
    wait_done(1, tag);
    chk({tag, ".we_pulses"}, we_cnt, 2);
    chk({tag, ".nib_hi"}, qget(nib_q, 0), int'(hi));
    chk({tag, ".nib_lo"}, qget(nib_q, 1), int'(lo));
    chk({tag, ".rs_hi"}, qget(rsl_q, 0), int'(r));
    chk({tag, ".rs_lo"}, qget(rsl_q, 1), int'(r));
    chk({tag, ".settle"}, done_cyc - fin_cyc - 1, dly);
    @(negedge clk);
    chk({tag, ".done_pulse"}, int'(done), 0);
    chk({tag, ".done_cnt"}, done_cnt, 1);
    chk({tag, ".busy_lo"}, int'(busy), 0);
    chk({tag, ".db_hold"}, int'(lcd_db), int'(lo));
    chk({tag, ".rw"}, int'(lcd_rw), 0);
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic [3:0] hi;
    logic [3:0] lo;
    int         dly;
    string      name;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int k;
    vecs[0] = '{1'b1, 8'hA5, 4'hA, 4'h5, D,  "data_a5"};
    vecs[1] = '{1'b0, 8'h01, 4'h0, 4'h1, LD, "clear"};
    vecs[2] = '{1'b0, 8'h02, 4'h0, 4'h2, LD, "home"};
    vecs[3] = '{1'b1, 8'h02, 4'h0, 4'h2, D,  "data_02"};
    vecs[4] = '{1'b0, 8'h38, 4'h3, 4'h8, D,  "cmd_38"};

    rst = 1'b1; start = 1'b0; rs_in = 1'b0; data_in = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.outs", int'({wr_enable, lcd_rs, lcd_rw, lcd_db, busy, done}), 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++)
      run_byte(vecs[i].rs, vecs[i].data, vecs[i].hi, vecs[i].lo, vecs[i].dly, vecs[i].name);

    // Start while busy must not disturb the byte in flight.
    clear_logs();
    @(negedge clk);
    start = 1'b1; rs_in = 1'b0; data_in = 8'h38;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; rs_in = 1'b1; data_in = 8'hFF;
    repeat (4) @(negedge clk);
    start = 1'b0;
    wait_done(1, "busy_start");
    repeat (20) @(negedge clk);
    chk("busy_start.we_pulses", we_cnt, 2);
    chk("busy_start.nib_hi", qget(nib_q, 0), 3);
    chk("busy_start.nib_lo", qget(nib_q, 1), 8);
    chk("busy_start.rs", qget(rsl_q, 1), 0);
    chk("busy_start.done_cnt", done_cnt, 1);

    // Reset during HI_WAIT aborts the byte.
    clear_logs();
    @(negedge clk);
    start = 1'b1; rs_in = 1'b1; data_in = 8'h5A;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!wr_enable && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("midrst.reached_hi_wait", int'(wr_enable), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.busy", int'(busy), 0);
    chk("midrst.db", int'(lcd_db), 0);
    repeat (20) @(negedge clk);
    chk("midrst.we_pulses", we_cnt, 1);
    chk("midrst.no_done", done_cnt, 0);
    run_byte(1'b1, 8'hC3, 4'hC, 4'h3, D, "after_rst");

    // Back-to-back bytes with start held high.
    clear_logs();
    @(negedge clk);
    start = 1'b1; rs_in = 1'b1; data_in = 8'h41;
    wait_done(1, "b2b.first");
    start = 1'b0;
    k = 0;
    while (we_cnt < 3 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("b2b.gap", qget(we_cyc, 2) - done_cyc, 2);
    wait_done(2, "b2b.second");
    chk("b2b.we_pulses", we_cnt, 4);
    chk("b2b.nib_hi2", qget(nib_q, 2), 4);
    chk("b2b.nib_lo2", qget(nib_q, 3), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_byte_sender.md
LCD_BYTE_SENDER -- requirements
Module: lcd_byte_sender

Interface
REQ-001 SHALL have parameter DELAY_CYCLES, default 2000, giving the post-byte settle delay in clk cycles (40 us at 50 MHz); legal range is 1 or more.
REQ-002 SHALL have parameter LONG_DELAY_CYCLES, default 82000, giving the settle delay for clear/home commands (1.64 ms at 50 MHz); legal range is DELAY_CYCLES or more.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: byte-send request, sampled only in IDLE.
REQ-006 SHALL have port rs_in, input, 1 bit: register select for the byte (0 = command, 1 = data).
REQ-007 SHALL have port data_in, input, 8 bits: the byte to send, captured when start is accepted.
REQ-008 SHALL have port wr_finish, input, 1 bit: completion pulse from the downstream write_cycle stage.
REQ-009 SHALL have port wr_enable, output, 1 bit: nibble-write request to the write_cycle stage.
REQ-010 SHALL have port lcd_rs, output, 1 bit: LCD RS line.
REQ-011 SHALL have port lcd_rw, output, 1 bit: LCD RW line, constant 0.
REQ-012 SHALL have port lcd_db, output, 4 bits: LCD DB[7:4] data nibble.
REQ-013 SHALL have port busy, output, 1 bit: high from start acceptance until the delay ends.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when the byte has been sent and has settled.

Function
REQ-015 SHALL implement the state machine IDLE, HI_REQ, HI_WAIT, LO_REQ, LO_WAIT, DELAY; every output SHALL be registered.
REQ-016 IDLE: on start=1, SHALL latch data_in and rs_in, set lcd_db=data_in[7:4] and lcd_rs=rs_in, set busy=1, and go to HI_REQ.
REQ-017 HI_REQ and LO_REQ: wr_enable SHALL be high for exactly one cycle, after which the FSM goes to the matching WAIT state.
REQ-018 HI_WAIT: on wr_finish=1, SHALL set lcd_db=latched[3:0] and go to LO_REQ.
REQ-019 LO_WAIT: on wr_finish=1, SHALL load the delay counter with the selected delay minus 1 and go to DELAY.
REQ-020 DELAY: SHALL decrement the counter each cycle; at 0 it SHALL go to IDLE with busy=0 and done=1 for one cycle, so DELAY lasts exactly the selected delay in cycles.
REQ-021 lcd_db and lcd_rs SHALL be stable from 1 cycle before each wr_enable pulse until that nibble's wr_finish.
REQ-022 The counter width SHALL be $clog2(LONG_DELAY_CYCLES+1) bits; the counter SHALL never wrap below 0.
REQ-023 start while busy=1 SHALL be ignored and SHALL NOT alter the latched byte.
REQ-024 wr_finish outside HI_WAIT/LO_WAIT SHALL be ignored.
REQ-025 A wr_finish on the same cycle as a wr_enable pulse SHALL NOT be counted as completion of that pulse.
REQ-026 start=1 on the cycle done=1 is asserted SHALL be accepted, so back-to-back bytes incur no idle gap.
REQ-027 lcd_db SHALL hold the last nibble driven after completion, and lcd_rs SHALL hold the last value driven.

Reset
REQ-028 rst=1 SHALL set state=IDLE, busy=0, done=0, wr_enable=0, lcd_rs=0, lcd_rw=0, lcd_db=4'h0, counter=0 and latched byte=8'h00 at the next clk edge.
REQ-029 rst SHALL take priority over all other inputs; reset mid-operation SHALL abort the byte with no done pulse and no further wr_enable.

Configuration
REQ-030 With macro LCD_LONG_DELAY_EN defined, a byte with rs=0 and data 8'h01 or 8'h02 SHALL use LONG_DELAY_CYCLES, and all other bytes SHALL use DELAY_CYCLES.
REQ-031 Without LCD_LONG_DELAY_EN, every byte SHALL use DELAY_CYCLES, and LONG_DELAY_CYCLES SHALL affect only the counter width.

Verification
All scenarios use DELAY_CYCLES=4 and LONG_DELAY_CYCLES=10, with a write_cycle model that pulses wr_finish 3 cycles after each wr_enable.
REQ-032 Reset values: hold rst for 2 cycles -> all outputs 0, busy=0.
REQ-033 Data byte: start with rs=1, data=8'hA5 -> lcd_db=4'hA then 4'h5, lcd_rs=1, exactly 2 wr_enable pulses, done exactly 4 cycles after the 2nd wr_finish.
REQ-034 Clear command: rs=0, data=8'h01 -> done 10 cycles after the 2nd wr_finish with LCD_LONG_DELAY_EN defined, and 4 cycles without it.
REQ-035 Start while busy: start with 8'h38, then start with 8'hFF mid-byte -> only nibbles 3 and 8 are sent, and only one done pulse.
REQ-036 Reset mid-op: assert rst in HI_WAIT -> no further wr_enable, no done pulse, busy=0 the next cycle; a fresh start then completes normally.
REQ-037 Back-to-back: start held high -> the second byte's first wr_enable occurs 2 cycles after done.
